// File: rtl/alu_wb_stage.sv
// Writeback stage behind the ALU: in-order result FIFO feeding the register-file
// write port, with a program-ordered flags register and an unordered-compare counter.
module alu_wb_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic                       in_zero,
  input  logic [3:0]                 in_alu_op,
  input  logic [RD_W-1:0]            in_rd,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic                       wb_we,
  output logic [DATA_W-1:0]          wb_data,
  output logic [RD_W-1:0]            wb_rd,
  output logic [3:0]                 flags,
  output logic [15:0]                un_cnt,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] OP_FCMP = 4'b1000;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic [3:0]        alu_op;
    logic [RD_W-1:0]   rd;
  } wb_ent_t;

  wb_ent_t        mem [DEPTH];
  wb_ent_t        head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt;
  logic [1:0]     code;
  logic           push, pop;

  // flush blocks both sides of the handshake for the cycle it is high
  assign in_ready = (cnt < CW'(DEPTH)) && !flush;
  assign wb_valid = (cnt != '0);
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready && !flush;

  assign head     = mem[rd_ptr];
  assign code     = head.result[1:0];
  // Gate with wb_valid so stale slot contents never reach the port
  assign wb_data  = wb_valid ? head.result : '0;
  assign wb_rd    = wb_valid ? head.rd : '0;
  assign wb_we    = wb_valid && (head.rd != '0);
  assign count    = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{result: in_result, zero: in_zero, alu_op: in_alu_op, rd: in_rd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Flags only move on retirement so they follow program order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags  <= 4'b0000;
      un_cnt <= 16'h0000;
    end else if (pop) begin
      if (head.alu_op == OP_FCMP) begin
        flags <= {code == 2'b11, code == 2'b10, code == 2'b01, code == 2'b00};
        if (code == 2'b11 && un_cnt != 16'hFFFF) un_cnt <= un_cnt + 16'd1;
      end else begin
        flags[0] <= head.zero;
      end
    end
  end
endmodule

// File: tb/tb_alu_wb_stage.sv
// Randomized + directed bench for alu_wb_stage against a queue-based reference model.
module tb_alu_wb_stage;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int DEPTH  = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_result = '0;
  logic              in_zero = 1'b0;
  logic [3:0]        in_alu_op = '0;
  logic [RD_W-1:0]   in_rd = '0;
  logic              wb_valid;
  logic              wb_ready = 1'b0;
  logic              wb_we;
  logic [DATA_W-1:0] wb_data;
  logic [RD_W-1:0]   wb_rd;
  logic [3:0]        flags;
  logic [15:0]       un_cnt;
  logic              flush = 1'b0;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  alu_wb_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_alu_op(in_alu_op), .in_rd(in_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
    .wb_data(wb_data), .wb_rd(wb_rd), .flags(flags), .un_cnt(un_cnt),
    .flush(flush), .count(count)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic [3:0]  op;
    logic [4:0]  rd;
  } ent_t;

  ent_t        q[$];
  logic [3:0]  m_flags = 4'b0000;
  int unsigned m_un = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    bit ne;
    ne = (q.size() != 0);
    chk("wb_valid", 32'(wb_valid), 32'(ne));
    if (ne) begin
      chk("wb_data", wb_data, q[0].res);
      chk("wb_rd", 32'(wb_rd), 32'(q[0].rd));
      chk("wb_we", 32'(wb_we), 32'(q[0].rd != 0));
    end else begin
      chk("wb_data", wb_data, 32'd0);
      chk("wb_rd", 32'(wb_rd), 32'd0);
      chk("wb_we", 32'(wb_we), 32'd0);
    end
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH && !flush));
    chk("flags", 32'(flags), 32'(m_flags));
    chk("un_cnt", 32'(un_cnt), m_un);
    chk("count", 32'(count), 32'(q.size()));
  endtask

  // Advance the model across the coming rising edge using the inputs now applied
  task automatic model_edge();
    bit   acc, ret;
    ent_t e;
    acc = in_valid && (q.size() < DEPTH) && !flush;
    ret = (q.size() != 0) && wb_ready && !flush;
    if (flush) begin
      q.delete();
    end else begin
      if (ret) begin
        e = q.pop_front();
        if (e.op == 4'b1000) begin
          m_flags = 4'b0000;
          case (e.res[1:0])
            2'd0: m_flags[0] = 1'b1;
            2'd1: m_flags[1] = 1'b1;
            2'd2: m_flags[2] = 1'b1;
            default: begin
              m_flags[3] = 1'b1;
              if (m_un < 65535) m_un++;
            end
          endcase
        end else begin
          m_flags[0] = e.z;
        end
      end
      if (acc) begin
        e.res = in_result; e.z = in_zero; e.op = in_alu_op; e.rd = in_rd;
        q.push_back(e);
      end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] r, input bit z, input logic [3:0] op,
                      input logic [4:0] rd, input bit wr, input bit fl);
    @(negedge clk);
    in_valid = v; in_result = r; in_zero = z; in_alu_op = op; in_rd = rd;
    wb_ready = wr; flush = fl;
    #1;
    check_model();
    model_edge();
  endtask

  task automatic chk_reset_vals();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_un_cnt", 32'(un_cnt), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
  endtask

  // Asynchronous assertion between edges, release on a falling edge
  task automatic rst_pulse();
    #2;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    #1;
    chk_reset_vals();
    q.delete(); m_flags = 4'b0000; m_un = 0;
    @(posedge clk); #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0]  sv_flags;
  logic [15:0] sv_un;

  initial begin
    #3;
    chk_reset_vals();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // basic path
    step(1, 32'h1234, 0, 4'b0000, 5'd3, 1, 0);
    @(posedge clk); #1;
    chk("basic_valid", 32'(wb_valid), 32'd1);
    chk("basic_we", 32'(wb_we), 32'd1);
    chk("basic_data", wb_data, 32'h1234);
    chk("basic_rd", 32'(wb_rd), 32'd3);
    step(0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk("basic_flags", 32'(flags), 32'd0);

    // backpressure
    for (int i = 0; i < 3; i++) step(1, 32'hA0 + i, 0, 4'b0010, 5'd4 + 5'(i), 0, 0);
    @(posedge clk); #1;
    chk("bp_count", 32'(count), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head", wb_data, 32'hA0);
    step(0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    chk("bp_second", wb_data, 32'hA1);
    step(0, 0, 0, 0, 0, 1, 0);

    // compare flag sequence
    rst_pulse();
    begin
      logic [3:0]  exp_f [4];
      logic [31:0] rs [4];
      rs[0] = 2; rs[1] = 1; rs[2] = 0; rs[3] = 3;
      exp_f[0] = 4'b0100; exp_f[1] = 4'b0010; exp_f[2] = 4'b0001; exp_f[3] = 4'b1000;
      for (int i = 0; i < 4; i++) begin
        step(1, rs[i], 0, 4'b1000, 5'd7, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        @(posedge clk); #1;
        chk("cmp_flags", 32'(flags), 32'(exp_f[i]));
      end
      chk("cmp_un_cnt", 32'(un_cnt), 32'd1);
    end

    // rd=0 non-compare after an LT compare
    step(1, 32'd2, 0, 4'b1000, 5'd9, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 32'd0, 1, 4'b0001, 5'd0, 0, 0);
    @(posedge clk); #1;
    chk("rd0_we", 32'(wb_we), 32'd0);
    chk("rd0_valid", 32'(wb_valid), 32'd1);
    step(0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk("rd0_flags", 32'(flags), 32'b0101);

    // flush with two entries buffered
    step(1, 32'd3, 0, 4'b1000, 5'd1, 0, 0);
    step(1, 32'd3, 0, 4'b1000, 5'd2, 0, 0);
    @(posedge clk); #1;
    sv_flags = flags; sv_un = un_cnt;
    step(1, 32'd5, 0, 4'b0000, 5'd3, 1, 1);
    @(posedge clk); #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(wb_valid), 32'd0);
    chk("flush_flags", 32'(flags), 32'(sv_flags));
    chk("flush_un", 32'(un_cnt), 32'(sv_un));
    step(0, 0, 0, 0, 0, 1, 0);

    // randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 2500; i++) begin
      logic [3:0]  op;
      logic [4:0]  rd;
      op = ($urandom_range(0, 1) == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 9) < 7, $urandom, 1'($urandom), op, rd,
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) rst_pulse();
    end

    // un_cnt saturation, then reset with entries in flight
    rst_pulse();
    for (int i = 0; i < 65540; i++) step(1, 32'd3, 0, 4'b1000, 5'd1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk("sat_un_cnt", 32'(un_cnt), 32'h0000FFFF);
    chk("sat_flags", 32'(flags), 32'b1000);
    step(1, 32'h55, 0, 4'b0000, 5'd6, 0, 0);
    step(1, 32'h66, 0, 4'b0000, 5'd7, 0, 0);
    rst_pulse();
    step(0, 0, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
